// File: rtl/lc3_fetch_pkg.sv
// lc3_fetch_pkg
// Shared definitions for the SLC-3 instruction-fetch stage:
//   fetch_state_t     - fetch sequencer states
//   DEFAULT_RESET_PC  - PC value loaded on reset unless overridden
//   WAIT_CNT_W        - width of the memory wait counter (covers timeouts 1..255)
//   pc_increment()    - modulo-2^16 PC advance
package lc3_fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_ERR   = 3'd4
    } fetch_state_t;

    localparam logic [15:0] DEFAULT_RESET_PC = 16'h3000;
    localparam int          WAIT_CNT_W       = 8;

    // 16-bit add wraps naturally: 16'hFFFF advances to 16'h0000.
    function automatic logic [15:0] pc_increment(input logic [15:0] pc);
        return pc + 16'd1;
    endfunction

endpackage

// File: rtl/lc3_wait_timer.sv
// lc3_wait_timer
// Counts consecutive memory wait cycles for the fetch stage.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   clear    in   restart the count at zero
//   enable   in   this cycle is a non-ready wait cycle
//   expired  out  this enabled cycle is the WAIT_TIMEOUT-th consecutive one
// expired is combinational so the sequencer can leave on the same edge
// that samples the final non-ready cycle.
module lc3_wait_timer
    import lc3_fetch_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // Count value equals the number of earlier non-ready cycles, so the
    // terminal cycle is the one seen while the count is WAIT_TIMEOUT-1.
    localparam logic [WAIT_CNT_W-1:0] TERM_CNT = WAIT_CNT_W'(WAIT_TIMEOUT - 1);

    logic [WAIT_CNT_W-1:0] count_r;

    assign expired = enable && (count_r == TERM_CNT);

    // Wait-cycle counter: cleared per fetch, advances on each non-ready cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {WAIT_CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {WAIT_CNT_W{1'b0}};
        end else if (enable && !expired) begin
            count_r <= count_r + {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/lc3_fetch_unit.sv
// lc3_fetch_unit
// Instruction-fetch stage of the SLC-3 datapath. Holds PC, reads one word
// per fetch over a ready-based memory handshake, captures it into IR and
// presents IR downstream with a valid/ready handshake. IR stays constant
// while presented because the register file decodes its select fields.
//
// Parameters: RESET_PC (PC after reset), WAIT_TIMEOUT (1..255 wait cycles
// before the sticky fetch error).
// Optional feature macro: LC3_FETCH_REDIRECT_EN adds redirect_valid /
// redirect_pc; without it PC only ever increments.
//
// Ports:
//   Clk        in   system clock
//   Reset      in   asynchronous active-low reset
//   Run        in   fetch enable
//   mem_addr   out  address of the word being fetched
//   mem_rd     out  read request (high only while waiting on memory)
//   mem_rdata  in   read data, valid with mem_ready
//   mem_ready  in   memory completion strobe
//   IR         out  fetched instruction
//   ir_valid   out  IR holds an unconsumed instruction
//   ir_ready   in   downstream accepts IR
//   PC         out  address of the next word to fetch
//   redirect_valid / redirect_pc  in  PC load request and target (optional)
//   fetch_err  out  sticky memory-timeout flag, cleared only by Reset
module lc3_fetch_unit
    import lc3_fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC     = DEFAULT_RESET_PC,
    parameter int          WAIT_TIMEOUT = 15
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Run,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic [15:0] IR,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [15:0] PC,
`ifdef LC3_FETCH_REDIRECT_EN
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
`endif
    output logic        fetch_err
);

    fetch_state_t state_r;
    fetch_state_t state_nxt_s;

    logic [15:0] pc_r;
    logic [15:0] pc_nxt_s;
    logic [15:0] mem_addr_r;
    logic [15:0] ir_r;
    logic        mem_rd_r;
    logic        ir_valid_r;
    logic        fetch_err_r;
    logic        pend_valid_r;
    logic        pend_valid_nxt_s;
    logic [15:0] pend_pc_r;
    logic [15:0] pend_pc_nxt_s;
    logic        keep_word_s;
    logic        redir_s;
    logic [15:0] redir_pc_s;
    logic        timer_clear_s;
    logic        timer_en_s;
    logic        timer_expired_s;

`ifdef LC3_FETCH_REDIRECT_EN
    assign redir_s    = redirect_valid;
    assign redir_pc_s = redirect_pc;
`else
    assign redir_s    = 1'b0;
    assign redir_pc_s = 16'h0000;
`endif

    assign timer_clear_s = (state_r == ST_ADDR);
    assign timer_en_s    = (state_r == ST_WAIT) && !mem_ready;

    lc3_wait_timer #(
        .WAIT_TIMEOUT (WAIT_TIMEOUT)
    ) u_wait_timer (
        .clk     (Clk),
        .rst_n   (Reset),
        .clear   (timer_clear_s),
        .enable  (timer_en_s),
        .expired (timer_expired_s)
    );

    // Next-state, next-PC and pending-redirect decisions.
    always_comb begin
        state_nxt_s      = state_r;
        pc_nxt_s         = pc_r;
        pend_valid_nxt_s = pend_valid_r;
        pend_pc_nxt_s    = pend_pc_r;
        keep_word_s      = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (redir_s) begin
                    pc_nxt_s = redir_pc_s;
                end else begin
                    pc_nxt_s = pc_r;
                end
                if (Run) begin
                    state_nxt_s = ST_ADDR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end

            ST_ADDR: begin
                // A redirect here cannot stop the fetch already being
                // launched; remember it and apply it on completion.
                if (redir_s) begin
                    pend_valid_nxt_s = 1'b1;
                    pend_pc_nxt_s    = redir_pc_s;
                end else begin
                    pend_valid_nxt_s = pend_valid_r;
                    pend_pc_nxt_s    = pend_pc_r;
                end
                state_nxt_s = ST_WAIT;
            end

            ST_WAIT: begin
                if (mem_ready) begin
                    // A completion overrides the timeout in the same cycle.
                    // Any redirect (same-cycle or pending) discards the word.
                    pend_valid_nxt_s = 1'b0;
                    if (redir_s) begin
                        pc_nxt_s    = redir_pc_s;
                        state_nxt_s = ST_ADDR;
                    end else if (pend_valid_r) begin
                        pc_nxt_s    = pend_pc_r;
                        state_nxt_s = ST_ADDR;
                    end else begin
                        pc_nxt_s    = pc_increment(pc_r);
                        keep_word_s = 1'b1;
                        state_nxt_s = ST_ISSUE;
                    end
                end else if (timer_expired_s) begin
                    pend_valid_nxt_s = 1'b0;
                    state_nxt_s      = ST_ERR;
                end else begin
                    if (redir_s) begin
                        pend_valid_nxt_s = 1'b1;
                        pend_pc_nxt_s    = redir_pc_s;
                    end else begin
                        pend_valid_nxt_s = pend_valid_r;
                        pend_pc_nxt_s    = pend_pc_r;
                    end
                    state_nxt_s = ST_WAIT;
                end
            end

            ST_ISSUE: begin
                // A redirect squashes the held word even if ir_ready is high.
                if (redir_s || ir_ready) begin
                    if (redir_s) begin
                        pc_nxt_s = redir_pc_s;
                    end else begin
                        pc_nxt_s = pc_r;
                    end
                    if (Run) begin
                        state_nxt_s = ST_ADDR;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end

            ST_ERR: begin
                state_nxt_s = ST_ERR;
            end

            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r      <= ST_IDLE;
            pc_r         <= RESET_PC;
            mem_addr_r   <= 16'h0000;
            ir_r         <= 16'h0000;
            mem_rd_r     <= 1'b0;
            ir_valid_r   <= 1'b0;
            fetch_err_r  <= 1'b0;
            pend_valid_r <= 1'b0;
            pend_pc_r    <= 16'h0000;
        end else begin
            state_r      <= state_nxt_s;
            pc_r         <= pc_nxt_s;
            pend_valid_r <= pend_valid_nxt_s;
            pend_pc_r    <= pend_pc_nxt_s;
            // Status outputs are decoded from the upcoming state so they
            // line up with the state register without extra delay.
            mem_rd_r     <= (state_nxt_s == ST_WAIT);
            ir_valid_r   <= (state_nxt_s == ST_ISSUE);
            fetch_err_r  <= (state_nxt_s == ST_ERR);
            if (state_r == ST_ADDR) begin
                mem_addr_r <= pc_r;
            end else begin
                mem_addr_r <= mem_addr_r;
            end
            if (keep_word_s) begin
                ir_r <= mem_rdata;
            end else begin
                ir_r <= ir_r;
            end
        end
    end

    assign mem_addr  = mem_addr_r;
    assign mem_rd    = mem_rd_r;
    assign IR        = ir_r;
    assign ir_valid  = ir_valid_r;
    assign PC        = pc_r;
    assign fetch_err = fetch_err_r;

endmodule

// File: tb/tb_lc3_fetch_unit.sv
// tb_lc3_fetch_unit
// Directed bench for lc3_fetch_unit. A memory responder with programmable
// latency serves the main instance; a transaction-level model (expected PC,
// expected word per address, request/issue pairing) is checked every cycle.
// A second instance starting at 16'hFFFF with WAIT_TIMEOUT=3 covers PC wrap
// and the short-timeout boundary.
module tb_lc3_fetch_unit;

    logic        Clk       = 1'b0;
    logic        Reset     = 1'b1;
    logic        Run       = 1'b0;
    logic [15:0] mem_rdata = 16'h0000;
    logic        mem_ready = 1'b0;
    logic        ir_ready  = 1'b0;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [15:0] IR;
    logic        ir_valid;
    logic [15:0] PC;
    logic        fetch_err;

    logic        w_run       = 1'b0;
    logic        w_mem_ready = 1'b0;
    logic        w_ir_ready  = 1'b0;
    logic [15:0] w_mem_rdata = 16'h0F0F;
    logic [15:0] w_mem_addr;
    logic        w_mem_rd;
    logic [15:0] w_ir;
    logic        w_ir_valid;
    logic [15:0] w_pc;
    logic        w_fetch_err;

`ifdef LC3_FETCH_REDIRECT_EN
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc    = 16'h0000;
`endif

    int checks    = 0;
    int failures  = 0;
    int latency   = 0;
    bit stray     = 1'b0;
    int wcnt      = 0;
    int transfers = 0;

    lc3_fetch_unit dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Run       (Run),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .IR        (IR),
        .ir_valid  (ir_valid),
        .ir_ready  (ir_ready),
        .PC        (PC),
`ifdef LC3_FETCH_REDIRECT_EN
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
`endif
        .fetch_err (fetch_err)
    );

    lc3_fetch_unit #(.RESET_PC(16'hFFFF), .WAIT_TIMEOUT(3)) dut_wrap (
        .Clk       (Clk),
        .Reset     (Reset),
        .Run       (w_run),
        .mem_addr  (w_mem_addr),
        .mem_rd    (w_mem_rd),
        .mem_rdata (w_mem_rdata),
        .mem_ready (w_mem_ready),
        .IR        (w_ir),
        .ir_valid  (w_ir_valid),
        .ir_ready  (w_ir_ready),
        .PC        (w_pc),
`ifdef LC3_FETCH_REDIRECT_EN
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
`endif
        .fetch_err (w_fetch_err)
    );

    always #5 Clk = ~Clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == 16'h3000) return 16'h1240;
        else return a ^ 16'hC3C3;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Advance through the next rising edge and settle just after it.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Memory responder: answers a request after 'latency' non-ready cycles;
    // optionally asserts mem_ready with junk data while no read is pending.
    always @(posedge Clk) begin
        #1;
        if (mem_rd === 1'b1) begin
            if (wcnt >= latency) begin
                mem_ready = 1'b1;
                mem_rdata = mem_word(mem_addr);
            end else begin
                mem_ready = 1'b0;
                mem_rdata = 16'hDEAD;
                wcnt++;
            end
        end else begin
            wcnt      = 0;
            mem_ready = stray;
            mem_rdata = 16'hBAD0;
        end
    end

    // Transaction model + per-cycle compare.
    logic [15:0] exp_pc   = 16'h3000;
    logic [15:0] cur_addr = 16'h0000;
    logic [15:0] prev_ir  = 16'h0000;
    bit          prev_rd  = 1'b0;
    bit          prev_iv  = 1'b0;
    bit          prev_err = 1'b0;
    bit          prev_xf  = 1'b0;
    int          rd_cycles = 0;

    always @(negedge Clk) begin
        if (!Reset) begin
            chk("rst_pc", PC, 16'h3000);
            chk("rst_iv", {15'd0, ir_valid}, 16'd0);
            chk("rst_rd", {15'd0, mem_rd}, 16'd0);
            chk("rst_err", {15'd0, fetch_err}, 16'd0);
            exp_pc    = 16'h3000;
            prev_rd   = 1'b0;
            prev_iv   = 1'b0;
            prev_err  = 1'b0;
            prev_xf   = 1'b0;
            rd_cycles = 0;
        end else begin
            if (mem_rd) begin
                if (!prev_rd) begin
                    chk("req_addr", mem_addr, exp_pc);
                    cur_addr  = exp_pc;
                    rd_cycles = 0;
                end
                rd_cycles++;
                chk("rd_iv_excl", {15'd0, ir_valid}, 16'd0);
            end
            if (ir_valid && !prev_iv) begin
                chk("issue_ir", IR, mem_word(cur_addr));
                chk("issue_wait", 16'(rd_cycles), 16'(latency + 1));
                exp_pc = cur_addr + 16'd1;
            end
            if (ir_valid && prev_iv && !prev_xf)
                chk("ir_hold", IR, prev_ir);
            chk("pc_track", PC, exp_pc);
            if (fetch_err) begin
                chk("err_rd", {15'd0, mem_rd}, 16'd0);
                chk("err_iv", {15'd0, ir_valid}, 16'd0);
                if (!prev_err) chk("timeout_cycles", 16'(rd_cycles), 16'd15);
            end
            prev_xf = ir_valid && ir_ready;
            if (prev_xf) transfers++;
            prev_rd  = mem_rd;
            prev_iv  = ir_valid;
            prev_err = fetch_err;
            prev_ir  = IR;
        end
    end

    initial begin
        int t0;
        #1 Reset = 1'b0;
        #1;
        chk("lit_rst_pc", PC, 16'h3000);
        chk("lit_rst_ir", IR, 16'h0000);
        chk("lit_rst_addr", mem_addr, 16'h0000);
        chk("lit_wrap_rst_pc", w_pc, 16'hFFFF);
        step();
        step();
        Reset = 1'b1;
        step();

        // First fetch, zero-wait memory, downstream stalled.
        Run = 1'b1;
        step();
        chk("lat_n_rd", {15'd0, mem_rd}, 16'd0);
        step();
        chk("lat_n1_rd", {15'd0, mem_rd}, 16'd1);
        chk("lat_n1_addr", mem_addr, 16'h3000);
        step();
        chk("lat_n2_iv", {15'd0, ir_valid}, 16'd1);
        chk("lat_n2_ir", IR, 16'h1240);
        chk("lat_n2_pc", PC, 16'h3001);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_iv", {15'd0, ir_valid}, 16'd1);
            chk("stall_ir", IR, 16'h1240);
        end
        ir_ready = 1'b1;
        step();
        chk("xfer_iv_drop", {15'd0, ir_valid}, 16'd0);
        chk("one_transfer", 16'(transfers), 16'd1);
        step();
        chk("next_addr", mem_addr, 16'h3001);
        chk("next_rd", {15'd0, mem_rd}, 16'd1);

        // Back-to-back stream with stray mem_ready outside WAIT.
        stray = 1'b1;
        repeat (3) step();
        t0 = transfers;
        repeat (12) step();
        chk("throughput", 16'(transfers - t0), 16'd4);
        Run = 1'b0;
        repeat (8) step();
        chk("stop_rd", {15'd0, mem_rd}, 16'd0);
        chk("stop_iv", {15'd0, ir_valid}, 16'd0);
        stray = 1'b0;

        // Dropping Run mid-WAIT still completes and issues the word.
        latency = 2;
        Run = 1'b1;
        for (int i = 0; i < 5 && !mem_rd; i++) step();
        chk("run0_rd_seen", {15'd0, mem_rd}, 16'd1);
        Run = 1'b0;
        t0 = transfers;
        for (int i = 0; i < 10 && !ir_valid; i++) step();
        chk("run0_issue", {15'd0, ir_valid}, 16'd1);
        repeat (4) step();
        chk("run0_idle_rd", {15'd0, mem_rd}, 16'd0);
        chk("run0_one_xfer", 16'(transfers - t0), 16'd1);

        // Ready in the 15th WAIT cycle wins over the timeout.
        latency = 14;
        Run = 1'b1;
        for (int i = 0; i < 30 && !ir_valid; i++) step();
        chk("late_issue", {15'd0, ir_valid}, 16'd1);
        chk("late_no_err", {15'd0, fetch_err}, 16'd0);
        Run = 1'b0;
        repeat (4) step();

        // Memory never answers: sticky error.
        latency = 1000;
        Run = 1'b1;
        for (int i = 0; i < 40 && !fetch_err; i++) step();
        chk("timeout_err", {15'd0, fetch_err}, 16'd1);
        stray = 1'b1;
        for (int i = 0; i < 10; i++) begin
            Run = i[0];
            step();
            chk("err_sticky", {15'd0, fetch_err}, 16'd1);
        end
        stray = 1'b0;
        Reset = 1'b0;
        step();
        chk("err_cleared", {15'd0, fetch_err}, 16'd0);
        Reset = 1'b1;

        // Asynchronous reset mid-WAIT takes effect before the next edge.
        latency = 5;
        Run = 1'b1;
        for (int i = 0; i < 5 && !mem_rd; i++) step();
        step();
        chk("pre_rst_rd", {15'd0, mem_rd}, 16'd1);
        #2 Reset = 1'b0;
        #1;
        chk("async_pc", PC, 16'h3000);
        chk("async_iv", {15'd0, ir_valid}, 16'd0);
        chk("async_rd", {15'd0, mem_rd}, 16'd0);
        chk("async_addr", mem_addr, 16'h0000);
        chk("async_ir", IR, 16'h0000);
        Run = 1'b0;
        step();
        Reset = 1'b1;
        step();

        // Wrap instance: fetch at 16'hFFFF, then a 3-cycle timeout at 16'h0000.
        chk("wrap_start_pc", w_pc, 16'hFFFF);
        w_run = 1'b1;
        w_ir_ready = 1'b1;
        w_mem_ready = 1'b1;
        step();
        chk("wrap_addr_state_rd", {15'd0, w_mem_rd}, 16'd0);
        step();
        chk("wrap_req_addr", w_mem_addr, 16'hFFFF);
        step();
        chk("wrap_iv", {15'd0, w_ir_valid}, 16'd1);
        chk("wrap_ir", w_ir, 16'h0F0F);
        chk("wrap_pc", w_pc, 16'h0000);
        w_mem_ready = 1'b0;
        step();
        chk("wrap_iv_drop", {15'd0, w_ir_valid}, 16'd0);
        step();
        chk("wrap_next_addr", w_mem_addr, 16'h0000);
        chk("wrap_next_rd", {15'd0, w_mem_rd}, 16'd1);
        step();
        chk("wrap_to1", {15'd0, w_fetch_err}, 16'd0);
        step();
        chk("wrap_to2", {15'd0, w_fetch_err}, 16'd0);
        step();
        chk("wrap_to3", {15'd0, w_fetch_err}, 16'd1);
        chk("wrap_err_rd", {15'd0, w_mem_rd}, 16'd0);
        chk("wrap_err_pc", w_pc, 16'h0000);
        w_run = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lc3_fetch_unit.md
# lc3_fetch_unit

Instruction-fetch stage of the SLC-3 datapath, directly upstream of the register file and decode logic. Holds the PC, issues word reads to memory over a ready-based handshake, captures the returned word into IR, and presents IR to the register-file/decode stage with a valid/ready handshake. IR[11:9], IR[8:6] and IR[2:0] feed the register file's DR/SR1/SR2 selects, so IR must stay stable while it is presented.

## Interface
- RESET_PC, 16'h3000, PC value loaded on reset
- WAIT_TIMEOUT, 15, max WAIT cycles before a fetch error (1..255)
- Clk  in  1  system clock, all state updates on rising edge
- Reset  in  1  asynchronous, active-low reset
- Run  in  1  fetch enable
- mem_addr  out  16  read address (PC of the word being fetched)
- mem_rd  out  1  read request
- mem_rdata  in  16  read data, valid when mem_ready=1
- mem_ready  in  1  memory completion strobe
- IR  out  16  fetched instruction
- ir_valid  out  1  IR holds an unconsumed instruction
- ir_ready  in  1  downstream accepts IR
- PC  out  16  address of the next word to fetch
- fetch_err  out  1  sticky memory-timeout flag
- redirect_valid  in  1  load PC (LC3_FETCH_REDIRECT_EN only)
- redirect_pc  in  16  redirect target (LC3_FETCH_REDIRECT_EN only)

## Operation
- States: IDLE, ADDR, WAIT, ISSUE, ERR.
- IDLE: Run=1 -> ADDR.
- ADDR: latch mem_addr<=PC, clear wait counter -> WAIT.
- WAIT: mem_rd=1, mem_addr held. mem_ready=1 -> IR<=mem_rdata, PC<=PC+1, -> ISSUE. Counter increments each WAIT cycle without mem_ready; counter reaching WAIT_TIMEOUT -> ERR.
- ISSUE: ir_valid=1, IR held. Transfer on edge with ir_valid&&ir_ready; then Run=1 -> ADDR, Run=0 -> IDLE. No transfer: stay.
- ERR: fetch_err=1, mem_rd=0, ir_valid=0; exit only by Reset.
- Run=0 in ADDR/WAIT does not abort; current fetch completes and issues.
- PC arithmetic modulo 2^16: 16'hFFFF increments to 16'h0000.
- mem_rd is 0 in all states except WAIT.

## Timing
- Reset asserted (any state, any time): immediately PC=RESET_PC, IR=16'h0000, ir_valid=0, mem_rd=0, mem_addr=16'h0000, fetch_err=0, state IDLE; pending redirect cleared.
- Zero-wait memory (mem_ready high in first WAIT cycle): Run sampled at edge n -> mem_rd high after edge n+1 -> ir_valid high after edge n+2.
- Back-to-back with ir_ready=1 constant and zero-wait memory: one instruction per 3 cycles.
- mem_ready outside WAIT is ignored.
- Timeout: ERR entered on the edge where the WAIT_TIMEOUT-th consecutive non-ready WAIT cycle is sampled; mem_ready in that same cycle wins (capture, not ERR).

## Configuration
- LC3_FETCH_REDIRECT_EN defined: redirect ports exist. redirect_valid in IDLE/ISSUE: PC<=redirect_pc; in ISSUE the held IR is squashed (ir_valid drops next cycle, no transfer even if ir_ready=1 same edge) -> ADDR if Run else IDLE. redirect_valid in ADDR/WAIT: target stored as pending; on completion the fetched word is discarded, PC<=pending target (not +1), -> ADDR. Redirect beats PC increment. Ignored in ERR.
- Not defined: ports absent, PC only increments.

## Structure
- Package lc3_fetch_pkg: fetch_state_t enum, default RESET_PC constant, width constant for wait counter.
- One sub-module natural: lc3_wait_timer (clear, enable, terminal-count flag at WAIT_TIMEOUT).

## Test plan
- Reset low mid-WAIT -> PC=16'h3000, ir_valid=0, mem_rd=0 immediately, before next edge.
- Run=1, zero-wait memory returning 16'h1240 at 16'h3000 -> IR=16'h1240, ir_valid after 3 edges, PC=16'h3001.
- ir_ready=0 for 5 cycles then 1 -> IR stable at 16'h1240 all 5 cycles, one transfer, next mem_addr=16'h3001.
- mem_ready never asserted, WAIT_TIMEOUT=15 -> fetch_err=1 after 15 WAIT cycles, mem_rd=0, stays until Reset.
- PC=16'hFFFF fetch -> PC becomes 16'h0000, next mem_addr=16'h0000.
- (REDIRECT_EN) redirect_pc=16'h4000 pulsed during WAIT -> fetched word not issued, next mem_addr=16'h4000, PC=16'h4001 after that fetch.
